// File: rtl/tile_mask_writer.sv
// tile_mask_writer: writes one nonzero-flag byte per TILE_ELEMS-element tile into the mask RAM.
// Optional nz_count output (count of nonzero tiles in the job) with TILE_MASK_WRITER_COUNT_EN.
module tile_mask_writer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int TILE_ELEMS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_tiles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
`ifdef TILE_MASK_WRITER_COUNT_EN
   ,output logic [ADDR_W-1:0] nz_count
`endif
);
    localparam int CW = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_ELEMS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, num_q, num_d, tile_q, tile_d;
    logic [ADDR_W-1:0] addr_q, addr_d, nz_q, nz_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [7:0]        wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        nz_d    = nz_q;
        case (state_q)
            IDLE: if (start) begin
                nz_d = '0;
                if (num_tiles != '0) begin
                    base_d  = base_addr;
                    num_d   = num_tiles;
                    tile_d  = '0;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = ACCUM;
                end else begin
                    state_d = DONE;
                end
            end
            ACCUM: if (in_valid) begin
                acc_d = acc_q | (in_data != '0);
                cnt_d = cnt_q + CW'(1);
                // Address/data registered here so they are valid during WRITE and hold afterwards.
                if (cnt_q == LAST) begin
                    addr_d  = base_q + tile_q;
                    wdata_d = {7'b0, acc_d};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d = 1'b0;
                cnt_d = '0;
                nz_d  = nz_q + ADDR_W'(acc_q);
                if (tile_q == num_q - ADDR_W'(1)) begin
                    state_d = DONE;
                end else begin
                    tile_d  = tile_q + ADDR_W'(1);
                    state_d = ACCUM;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            tile_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            nz_q    <= nz_d;
        end
    end

    assign in_ready  = state_q == ACCUM;
    assign mem_we    = state_q == WRITE;
    assign busy      = (state_q == ACCUM) || (state_q == WRITE);
    assign done      = state_q == DONE;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef TILE_MASK_WRITER_COUNT_EN
    assign nz_count  = nz_q;
`endif
endmodule

// File: tb/tb_tile_mask_writer.sv
// tb_tile_mask_writer: randomized jobs checked against a per-tile reference model.
module tb_tile_mask_writer;
    localparam int T  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [AW-1:0] base_addr = '0, num_tiles = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, busy, done, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
`ifdef TILE_MASK_WRITER_COUNT_EN
    logic [AW-1:0] nz_count;
`endif

    int checks = 0, errors = 0;
    logic [7:0] elems[$];

    tile_mask_writer #(.ADDR_W(AW), .DATA_W(DW), .TILE_ELEMS(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
`ifdef TILE_MASK_WRITER_COUNT_EN
       ,.nz_count(nz_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rand(input int n);
        elems.delete();
        for (int t = 0; t < n; t++) begin
            bit zt = $urandom_range(1, 0) == 1;
            for (int j = 0; j < T; j++)
                elems.push_back((zt || $urandom_range(2, 0) != 0) ? 8'h00 : 8'($urandom_range(255, 1)));
        end
    endtask

    // Called at posedge+1; elems must hold n*T values.
    task automatic run_job(input logic [15:0] b, input logic [15:0] n, input bit rnd, input bit restart);
        logic [15:0] ea[$], ga[$];
        logic [7:0]  ed[$], gd[$];
        int k, idx, nzt, budget;
        bit dv, rdy, bad, seen;
        nzt = 0;
        for (int t = 0; t < int'(n); t++) begin
            bit any = 1'b0;
            for (int j = 0; j < T; j++) any |= elems[t*T+j] != 8'h00;
            ea.push_back(b + 16'(t));
            ed.push_back({7'b0, any});
            nzt += int'(any);
        end
        start = 1'b1; base_addr = b; num_tiles = n; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 16'($urandom); num_tiles = 16'($urandom);
        k = 0; idx = 0; dv = 1'b0; rdy = 1'b0; bad = 1'b0; seen = 1'b0;
        budget = int'(n) * (T + 1) * (rnd ? 4 : 1) + 50;
        while (1) begin
            if (dv && rdy) idx++;
            if (mem_we) begin
                ga.push_back(mem_addr);
                gd.push_back(mem_wdata);
                if (in_ready) bad = 1'b1;
            end
            if (n != 0 && busy != !done) bad = 1'b1;
            if (n == 0 && busy) bad = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k > budget) break;
            rdy = in_ready;
            dv = idx < elems.size() && (!rnd || $urandom_range(1, 0) == 1);
            in_valid = dv;
            in_data = dv ? elems[idx] : 8'($urandom);
            if (restart && k == 3) begin
                start = 1'b1; base_addr = 16'($urandom); num_tiles = 16'($urandom_range(9, 1));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0; start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        if (!rnd) check("done_latency", k, int'(n) * (T + 1));
        check("elems_used", idx, elems.size());
        check("busy_ready_profile", 32'(bad), 32'd0);
        check("n_writes", ga.size(), ea.size());
        for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
            check("wr_addr", 32'(ga[i]), 32'(ea[i]));
            check("wr_data", 32'(gd[i]), 32'(ed[i]));
        end
`ifdef TILE_MASK_WRITER_COUNT_EN
        check("nz_count", 32'(nz_count), nzt);
`endif
        start = 1'b1; base_addr = 16'h4444; num_tiles = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_ignored", {busy, done, in_ready, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("idle_after_done", {busy, done, in_ready, mem_we}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check("rst_outs", {in_ready, busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
`ifdef TILE_MASK_WRITER_COUNT_EN
        check("rst_nz_count", 32'(nz_count), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        elems = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        run_job(16'h0010, 16'd3, 1'b0, 1'b0);

        elems.delete();
        run_job(16'h0123, 16'd0, 1'b0, 1'b0);

        elems.delete();
        for (int i = 0; i < 2 * T; i++) elems.push_back(8'($urandom_range(255, 1)));
        run_job(16'hFFFF, 16'd2, 1'b0, 1'b0);

        fill_rand(1);
        for (int j = 0; j < T - 1; j++) elems.push_back(8'h00);
        elems.push_back(8'h80);
        run_job(16'h0200, 16'd2, 1'b1, 1'b0);

        fill_rand(3);
        run_job(16'h0300, 16'd3, 1'b0, 1'b1);

        // Abort during ACCUM of tile 1: one element of tile 1 already accepted.
        start = 1'b1; base_addr = 16'h1234; num_tiles = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        repeat (T + 2) begin
            @(posedge clk); #1;
        end
        check("pre_abort_state", {busy, in_ready, mem_addr}, {2'b11, 16'h1234});
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {in_ready, busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
        in_valid = 1'b0;
        begin
            bit seen_bad = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (mem_we || done) seen_bad = 1'b1;
            end
            check("abort_no_write_done", 32'(seen_bad), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_rand(2);
        run_job(16'h0400, 16'd2, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(5, 1);
            fill_rand(n);
            run_job(16'($urandom), 16'(n), r[0], r == 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
